// File: rtl/glb_bank_rd_streamer_pkg.sv
// Shared definitions for the GLB bank read streamer: bank timing constant and FSM state encoding.
package global_buffer_param;
  localparam int RD_LATENCY = 3;
endpackage

package global_buffer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_stream_state_e;
endpackage

// File: rtl/glb_bank_rd_streamer_fifo.sv
// Return-data FIFO for the bank read streamer. When empty, a push is visible
// at the head in the same cycle, so pass-through traffic sees no bubble.
module glb_rd_stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty, full, pop_fire, do_write, do_read;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    valid_o  = !empty || push_i;
    head_o   = empty ? push_data_i : mem_q[rd_ptr_q];
    pop_fire = pop_i && valid_o;
    do_read  = pop_fire && !empty;
    // a bypassed word is consumed straight off the push bus and never stored
    do_write = push_i && !(empty && pop_fire) && (!full || do_read);
  end

  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_write) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_read)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_write) - CW'(do_read);
    end
  end
endmodule

// File: rtl/glb_bank_rd_streamer.sv
// Strided GLB bank read initiator with credit-limited issue and a valid/ready output stream.
// Optional multi-pass re-walk is enabled by defining GLB_RD_STREAM_REPEAT_EN.
//
// state | meaning
// IDLE  | waiting for cfg_start
// RUN   | issuing bank reads while credits allow
// DRAIN | all reads issued; waiting for returns and the stream to empty
module glb_bank_rd_streamer
  import global_buffer_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH  = 17,
  parameter int BANK_DATA_WIDTH  = 64,
  parameter int BANK_BYTE_OFFSET = 3,
  parameter int RD_LATENCY       = global_buffer_param::RD_LATENCY,
  parameter int FIFO_DEPTH       = 4,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_start,
  input  logic [BANK_ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [CNT_WIDTH-1:0]       cfg_num_words,
  input  logic [CNT_WIDTH-1:0]       cfg_stride,
`ifdef GLB_RD_STREAM_REPEAT_EN
  input  logic [CNT_WIDTH-1:0]       cfg_num_repeat,
`endif
  input  logic                       bank_busy,
  output logic                       packet_rd_en,
  output logic [BANK_ADDR_WIDTH-1:0] packet_rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0] packet_rd_data,
  input  logic                       packet_rd_data_valid,
  output logic [BANK_DATA_WIDTH-1:0] stream_data,
  output logic                       stream_valid,
  input  logic                       stream_ready,
  output logic                       stream_last,
  output logic                       busy,
  output logic                       done,
  output logic                       err_unexpected_rd
);
  // outstanding never exceeds FIFO_DEPTH; extra headroom covers the bank pipeline
  localparam int OW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BANK_ADDR_WIDTH-1:0] WORD_MASK = BANK_ADDR_WIDTH'((1 << BANK_BYTE_OFFSET) - 1);

  rd_stream_state_e           state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] addr_q, rd_addr_q, addr_step;
  logic [CNT_WIDTH-1:0]       stride_q, issue_left_q, push_left_q;
`ifdef GLB_RD_STREAM_REPEAT_EN
  logic [BANK_ADDR_WIDTH-1:0] base_addr_q;
  logic [CNT_WIDTH-1:0]       num_words_q, issue_rep_q, push_rep_q;
`endif
  logic [OW-1:0]              outstanding_q;
  logic                       rd_en_q, zero_done_q, err_q;
  logic [FCW-1:0]             fifo_count;
  logic [BANK_DATA_WIDTH:0]   fifo_head;
  logic [31:0]                occupancy;
  logic                       start_ok, issue, push, push_last, last_issue, drain_done;
  logic                       final_issue_pass, final_push_pass;

  always_comb begin
`ifdef GLB_RD_STREAM_REPEAT_EN
    final_issue_pass = (issue_rep_q == '0);
    final_push_pass  = (push_rep_q == '0);
`else
    final_issue_pass = 1'b1;
    final_push_pass  = 1'b1;
`endif
    start_ok   = (state_q == IDLE) && cfg_start;
    addr_step  = BANK_ADDR_WIDTH'(32'(stride_q) << BANK_BYTE_OFFSET);
    // a word leaving the stream this cycle frees its credit immediately
    occupancy  = 32'(outstanding_q) + 32'(fifo_count) - 32'(stream_valid && stream_ready);
    issue      = (state_q == RUN) && !bank_busy && (occupancy < 32'(FIFO_DEPTH));
    push       = packet_rd_data_valid && (outstanding_q != '0);
    push_last  = (push_left_q == CNT_WIDTH'(1)) && final_push_pass;
    last_issue = issue && (issue_left_q == CNT_WIDTH'(1)) && final_issue_pass;
    drain_done = (state_q == DRAIN) && (outstanding_q == '0) && (fifo_count == '0) && !push;

    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start && cfg_num_words != '0) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rd_addr_q     <= '0;
      stride_q      <= '0;
      issue_left_q  <= '0;
      push_left_q   <= '0;
`ifdef GLB_RD_STREAM_REPEAT_EN
      base_addr_q   <= '0;
      num_words_q   <= '0;
      issue_rep_q   <= '0;
      push_rep_q    <= '0;
`endif
      outstanding_q <= '0;
      rd_en_q       <= 1'b0;
      zero_done_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= issue;
      zero_done_q <= start_ok && (cfg_num_words == '0);
      if (issue) rd_addr_q <= addr_q;

      case ({issue, push})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase

      if (packet_rd_data_valid && outstanding_q == '0) err_q <= 1'b1;
      else if (start_ok) err_q <= 1'b0;

      if (start_ok) begin
        addr_q       <= cfg_start_addr & ~WORD_MASK;
        stride_q     <= cfg_stride;
        issue_left_q <= cfg_num_words;
        push_left_q  <= cfg_num_words;
`ifdef GLB_RD_STREAM_REPEAT_EN
        base_addr_q  <= cfg_start_addr & ~WORD_MASK;
        num_words_q  <= cfg_num_words;
        issue_rep_q  <= cfg_num_repeat;
        push_rep_q   <= cfg_num_repeat;
`endif
      end else begin
        if (issue) begin
`ifdef GLB_RD_STREAM_REPEAT_EN
          if (issue_left_q == CNT_WIDTH'(1) && !final_issue_pass) begin
            addr_q       <= base_addr_q;
            issue_left_q <= num_words_q;
            issue_rep_q  <= issue_rep_q - 1'b1;
          end else
`endif
          begin
            addr_q       <= addr_q + addr_step;
            issue_left_q <= issue_left_q - 1'b1;
          end
        end
        if (push) begin
`ifdef GLB_RD_STREAM_REPEAT_EN
          if (push_left_q == CNT_WIDTH'(1) && !final_push_pass) begin
            push_left_q <= num_words_q;
            push_rep_q  <= push_rep_q - 1'b1;
          end else
`endif
          begin
            push_left_q <= push_left_q - 1'b1;
          end
        end
      end
    end
  end

  glb_rd_stream_fifo #(
    .WIDTH(BANK_DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({push_last, packet_rd_data}),
    .pop_i       (stream_ready),
    .head_o      (fifo_head),
    .valid_o     (stream_valid),
    .count_o     (fifo_count)
  );

  assign stream_last       = fifo_head[BANK_DATA_WIDTH];
  assign stream_data       = fifo_head[BANK_DATA_WIDTH-1:0];
  assign packet_rd_en      = rd_en_q;
  assign packet_rd_addr    = rd_addr_q;
  assign busy              = (state_q != IDLE);
  assign done              = drain_done || zero_done_q;
  assign err_unexpected_rd = err_q;
endmodule

// File: tb/tb_glb_bank_rd_streamer.sv
// Directed bench for glb_bank_rd_streamer with a fixed-latency bank model.
// Define GLB_RD_STREAM_REPEAT_EN to also exercise the multi-pass mode.
module tb_glb_bank_rd_streamer;
  localparam int AW  = 17;
  localparam int DW  = 64;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [AW-1:0] cfg_start_addr;
  logic [15:0]   cfg_num_words, cfg_stride;
`ifdef GLB_RD_STREAM_REPEAT_EN
  logic [15:0]   cfg_num_repeat;
`endif
  logic          bank_busy;
  logic          packet_rd_en;
  logic [AW-1:0] packet_rd_addr;
  logic [DW-1:0] packet_rd_data;
  logic          packet_rd_data_valid;
  logic [DW-1:0] stream_data;
  logic          stream_valid, stream_ready, stream_last;
  logic          busy, done, err_unexpected_rd;

  always #5 clk = ~clk;

  glb_bank_rd_streamer dut (
    .clk                  (clk),
    .reset                (reset),
    .cfg_start            (cfg_start),
    .cfg_start_addr       (cfg_start_addr),
    .cfg_num_words        (cfg_num_words),
    .cfg_stride           (cfg_stride),
`ifdef GLB_RD_STREAM_REPEAT_EN
    .cfg_num_repeat       (cfg_num_repeat),
`endif
    .bank_busy            (bank_busy),
    .packet_rd_en         (packet_rd_en),
    .packet_rd_addr       (packet_rd_addr),
    .packet_rd_data       (packet_rd_data),
    .packet_rd_data_valid (packet_rd_data_valid),
    .stream_data          (stream_data),
    .stream_valid         (stream_valid),
    .stream_ready         (stream_ready),
    .stream_last          (stream_last),
    .busy                 (busy),
    .done                 (done),
    .err_unexpected_rd    (err_unexpected_rd)
  );

  function automatic logic [DW-1:0] bank_word(input logic [AW-1:0] a);
    return 64'hA5A5_0000_0000_0000 | {47'd0, a};
  endfunction

  // bank: request seen in cycle c returns data in cycle c+LAT; not tied to DUT reset
  logic [LAT-1:0] vpipe = '0;
  logic [AW-1:0]  apipe [LAT];
  always @(posedge clk) begin
    vpipe    <= {vpipe[LAT-2:0], packet_rd_en};
    apipe[0] <= packet_rd_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign packet_rd_data_valid = vpipe[LAT-1];
  assign packet_rd_data       = bank_word(apipe[LAT-1]);

  logic          busy_d = 1'b0;
  int            cyc = 0;
  logic [AW-1:0] iss_q [$];
  logic [64:0]   rx_q [$];
  int            rx_cyc [$];
  int            done_cnt = 0, done_cyc = 0, busy_viol = 0;

  always @(posedge clk) begin
    busy_d <= bank_busy;
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (packet_rd_en) begin
      iss_q.push_back(packet_rd_addr);
      // the request is registered, so it reflects bank_busy of the previous cycle
      if (busy_d) busy_viol <= busy_viol + 1;
    end
    if (stream_valid && stream_ready) begin
      rx_q.push_back({stream_last, stream_data});
      rx_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [AW-1:0] a, input logic [15:0] n, input logic [15:0] s);
    cfg_start_addr = a;
    cfg_num_words  = n;
    cfg_stride     = s;
    cfg_start      = 1'b1;
    tick();
    cfg_start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_done_once"}, 65'(done_cnt - d0), 65'd1);
    chk({tag, "_busy_after"}, 65'(busy), 65'd0);
  endtask

  // word i of n*passes: address restarts every n words, last only on the final word
  task automatic check_stream(input string tag, input int ib, input int rb, input logic [AW-1:0] a0,
                              input int stride, input int n, input int passes);
    logic [AW-1:0] ea;
    int            tot = n * passes;
    chk({tag, "_nissue"}, 65'(iss_q.size() - ib), 65'(tot));
    chk({tag, "_nrx"}, 65'(rx_q.size() - rb), 65'(tot));
    for (int i = 0; i < tot; i++) begin
      ea = a0 + AW'((i % n) * stride * 8);
      if (iss_q.size() > ib + i) chk({tag, "_addr"}, 65'(iss_q[ib+i]), 65'(ea));
      if (rx_q.size() > rb + i) chk({tag, "_word"}, rx_q[rb+i], {(i == tot - 1), bank_word(ea)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ib, rb, d0, v0, n, sv_bad;
    reset = 1'b1; cfg_start = 1'b0; cfg_start_addr = '0; cfg_num_words = '0; cfg_stride = '0;
    bank_busy = 1'b0; stream_ready = 1'b1;
`ifdef GLB_RD_STREAM_REPEAT_EN
    cfg_num_repeat = '0;
`endif
    repeat (3) tick();
    chk("rst_rd_en", 65'(packet_rd_en), 65'd0);
    chk("rst_rd_addr", 65'(packet_rd_addr), 65'd0);
    chk("rst_valid", 65'(stream_valid), 65'd0);
    chk("rst_last", 65'(stream_last), 65'd0);
    chk("rst_busy", 65'(busy), 65'd0);
    chk("rst_done", 65'(done), 65'd0);
    chk("rst_err", 65'(err_unexpected_rd), 65'd0);
    reset = 1'b0;
    tick();

    // full-rate pass-through: 8 words back-to-back, done the cycle after the last word
    ib = iss_q.size(); rb = rx_q.size(); d0 = done_cnt;
    start_xfer(17'h00100, 16'd8, 16'd1);
    wait_done("t1", d0);
    check_stream("t1", ib, rb, 17'h00100, 1, 8, 1);
    if (rx_q.size() >= rb + 8) begin
      chk("t1_back2back", 65'(rx_cyc[rb+7] - rx_cyc[rb]), 65'd7);
      chk("t1_done_lat", 65'(done_cyc - rx_cyc[rb+7]), 65'd1);
    end

    // address wraps at 2^17
    ib = iss_q.size(); rb = rx_q.size(); d0 = done_cnt;
    start_xfer(17'h1FFF8, 16'd3, 16'd2);
    wait_done("t2", d0);
    chk("t2_nissue", 65'(iss_q.size() - ib), 65'd3);
    if (iss_q.size() >= ib + 3) begin
      chk("t2_addr0", 65'(iss_q[ib]), 65'h1FFF8);
      chk("t2_addr1", 65'(iss_q[ib+1]), 65'h00008);
      chk("t2_addr2", 65'(iss_q[ib+2]), 65'h00018);
    end

    // consumer stalled: credits cap issue at FIFO_DEPTH, nothing lost after release
    ib = iss_q.size(); rb = rx_q.size(); d0 = done_cnt;
    stream_ready = 1'b0;
    start_xfer(17'h00000, 16'd16, 16'd1);
    repeat (20) tick();
    chk("t3_issued_stall", 65'(iss_q.size() - ib), 65'd4);
    chk("t3_rx_stall", 65'(rx_q.size() - rb), 65'd0);
    chk("t3_valid_stall", 65'(stream_valid), 65'd1);
    stream_ready = 1'b1;
    wait_done("t3", d0);
    check_stream("t3", ib, rb, 17'h00000, 1, 16, 1);

    // bank_busy in cycles 2..5 after the start pulse
    ib = iss_q.size(); rb = rx_q.size(); d0 = done_cnt; v0 = busy_viol;
    start_xfer(17'h00200, 16'd8, 16'd3);
    for (int k = 1; k <= 7; k++) begin
      bank_busy = (k >= 2 && k <= 5);
      tick();
    end
    bank_busy = 1'b0;
    wait_done("t4", d0);
    chk("t4_busy_viol", 65'(busy_viol - v0), 65'd0);
    check_stream("t4", ib, rb, 17'h00200, 3, 8, 1);

    // reset with two reads in flight
    ib = iss_q.size(); rb = rx_q.size();
    start_xfer(17'h00300, 16'd8, 16'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!packet_rd_en && n < 20);
    chk("t5_first_req", 65'(packet_rd_en), 65'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_rd_en", 65'(packet_rd_en), 65'd0);
    chk("t5_valid", 65'(stream_valid), 65'd0);
    chk("t5_busy", 65'(busy), 65'd0);
    chk("t5_err_pre", 65'(err_unexpected_rd), 65'd0);
    reset = 1'b0;
    sv_bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (stream_valid) sv_bad++;
    end
    #1;
    chk("t5_valid_quiet", 65'(sv_bad), 65'd0);
    chk("t5_err", 65'(err_unexpected_rd), 65'd1);
    chk("t5_issued", 65'(iss_q.size() - ib), 65'd2);
    chk("t5_rx", 65'(rx_q.size() - rb), 65'd0);

    // stride 0 re-reads one word; start clears the sticky error
    ib = iss_q.size(); rb = rx_q.size(); d0 = done_cnt;
    start_xfer(17'h0004B, 16'd3, 16'd0);
    chk("t6_err_clr", 65'(err_unexpected_rd), 65'd0);
    wait_done("t6", d0);
    check_stream("t6", ib, rb, 17'h00048, 0, 3, 1);

`ifdef GLB_RD_STREAM_REPEAT_EN
    // three passes of two words: A,B,A,B,A,B
    ib = iss_q.size(); rb = rx_q.size(); d0 = done_cnt;
    cfg_num_repeat = 16'd2;
    start_xfer(17'h00400, 16'd2, 16'd5);
    wait_done("t7", d0);
    check_stream("t7", ib, rb, 17'h00400, 5, 2, 3);
`endif

    // zero-length transfer: done the next cycle, no reads, never busy
    ib = iss_q.size();
    cfg_num_words = '0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("t8_done", 65'(done), 65'd1);
    chk("t8_busy", 65'(busy), 65'd0);
    tick();
    chk("t8_done_clr", 65'(done), 65'd0);
    repeat (6) tick();
    chk("t8_no_reads", 65'(iss_q.size() - ib), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
